// File: rtl/arm_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : arm_alu_arbiter
// Purpose  : Round-robin arbiter sharing one combinational ARM ALU between two
//            requesters, with a one-entry response register per port.
// Revision : 1.0
// ============================================================================
module arm_alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    input  logic        r1_valid,
    output logic        r0_ready,
    output logic        r1_ready,
    input  logic [31:0] r0_op1,
    input  logic [31:0] r0_op2,
    input  logic [31:0] r1_op1,
    input  logic [31:0] r1_op2,
    input  logic [3:0]  r0_sel,
    input  logic [3:0]  r1_sel,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    input  logic [31:0] alu_out,
    output logic        s0_valid,
    output logic        s1_valid,
    input  logic        s0_ready,
    input  logic        s1_ready,
    output logic [31:0] s0_result,
    output logic [31:0] s1_result,
    output logic        s0_n,
    output logic        s0_z,
    output logic        s1_n,
    output logic        s1_z,
    output logic        s0_wr,
    output logic        s1_wr
);

    localparam int c_DATA_W = 32;

    logic [1:0]          w_valid;
    logic [1:0]          w_s_ready;
    logic [1:0]          w_elig;
    logic [1:0]          w_grant;
    logic                w_wr;

    logic                r_last_grant;
    logic [1:0]          r_s_valid;
    logic [c_DATA_W-1:0] r_s_result [2];
    logic [1:0]          r_s_n;
    logic [1:0]          r_s_z;
    logic [1:0]          r_s_wr;

    assign w_valid   = {r1_valid, r0_valid};
    assign w_s_ready = {s1_ready, s0_ready};

    // A port may refill its response slot in the same cycle it is drained.
    assign w_elig = ~{2{reset}} & w_valid & (~r_s_valid | w_s_ready);

    assign w_grant[0] = w_elig[0] & (~w_elig[1] | r_last_grant);
    assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_last_grant);

    assign r0_ready = w_grant[0];
    assign r1_ready = w_grant[1];

    assign alu_op1    = w_grant[1] ? r1_op1 : r0_op1;
    assign alu_op2    = w_grant[1] ? r1_op2 : r0_op2;
    assign alu_op_sel = w_grant[1] ? r1_sel : r0_sel;

    // TST/TEQ/CMP/CMN (8..11) only update flags.
    assign w_wr = (alu_op_sel[3:2] != 2'b10);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_port
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s_valid[i]  <= 1'b0;
                    r_s_result[i] <= '0;
                    r_s_n[i]      <= 1'b0;
                    r_s_z[i]      <= 1'b0;
                    r_s_wr[i]     <= 1'b0;
                end else if (w_grant[i]) begin
                    r_s_valid[i]  <= 1'b1;
                    r_s_result[i] <= alu_out;
                    r_s_n[i]      <= alu_out[c_DATA_W-1];
                    r_s_z[i]      <= (alu_out == '0);
                    r_s_wr[i]     <= w_wr;
                end else if (w_s_ready[i]) begin
                    r_s_valid[i]  <= 1'b0;
                end
            end
        end
    endgenerate

    assign s0_valid  = r_s_valid[0];
    assign s1_valid  = r_s_valid[1];
    assign s0_result = r_s_result[0];
    assign s1_result = r_s_result[1];
    assign s0_n      = r_s_n[0];
    assign s1_n      = r_s_n[1];
    assign s0_z      = r_s_z[0];
    assign s1_z      = r_s_z[1];
    assign s0_wr     = r_s_wr[0];
    assign s1_wr     = r_s_wr[1];

endmodule
`default_nettype wire

// File: tb/tb_arm_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_alu_arbiter
// Purpose  : Directed and randomized bench for arm_alu_arbiter against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_arm_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_ready, r1_ready;
    logic [31:0] r0_op1, r0_op2, r1_op1, r1_op2;
    logic [3:0]  r0_sel, r1_sel;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_op_sel;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic [31:0] s0_result, s1_result;
    logic        s0_n, s0_z, s1_n, s1_z, s0_wr, s1_wr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one response slot per port plus round-robin pointer.
    logic        m_valid [2];
    logic [31:0] m_res   [2];
    logic        m_n     [2];
    logic        m_z     [2];
    logic        m_wr    [2];
    int          m_last;

    always #5 clk = ~clk;

    arm_alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .r0_valid   (r0_valid),
        .r1_valid   (r1_valid),
        .r0_ready   (r0_ready),
        .r1_ready   (r1_ready),
        .r0_op1     (r0_op1),
        .r0_op2     (r0_op2),
        .r1_op1     (r1_op1),
        .r1_op2     (r1_op2),
        .r0_sel     (r0_sel),
        .r1_sel     (r1_sel),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_op_sel (alu_op_sel),
        .alu_out    (alu_out),
        .s0_valid   (s0_valid),
        .s1_valid   (s1_valid),
        .s0_ready   (s0_ready),
        .s1_ready   (s1_ready),
        .s0_result  (s0_result),
        .s1_result  (s1_result),
        .s0_n       (s0_n),
        .s0_z       (s0_z),
        .s1_n       (s1_n),
        .s1_z       (s1_z),
        .s0_wr      (s0_wr),
        .s1_wr      (s1_wr)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0, 4'd8:  return a & b;
            4'd1, 4'd9:  return a ^ b;
            4'd2, 4'd10: return a - b;
            4'd3:        return b - a;
            4'd4, 4'd11: return a + b;
            4'd5:        return a + b + 32'd1;
            4'd6:        return a - b - 32'd1;
            4'd7:        return b - a - 32'd1;
            4'd12:       return a | b;
            4'd13:       return b;
            4'd14:       return a & ~b;
            default:     return ~b;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_op_sel, alu_op1, alu_op2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle, checks every output against the model, advances the model.
    task automatic cycle(input logic rst, input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                         input logic rd0, input logic rd1);
        logic        e [2];
        logic        rd [2];
        logic [31:0] a [2];
        logic [31:0] b [2];
        logic [3:0]  op [2];
        logic [31:0] res;
        int          g;
        reset = rst; r0_valid = v0; r1_valid = v1;
        r0_op1 = a0; r0_op2 = b0; r0_sel = op0;
        r1_op1 = a1; r1_op2 = b1; r1_sel = op1;
        s0_ready = rd0; s1_ready = rd1;
        a[0] = a0; b[0] = b0; op[0] = op0; a[1] = a1; b[1] = b1; op[1] = op1;
        rd[0] = rd0; rd[1] = rd1;
        @(negedge clk);
        e[0] = !rst && v0 && (!m_valid[0] || rd0);
        e[1] = !rst && v1 && (!m_valid[1] || rd1);
        if (e[0] && e[1])  g = (m_last == 0) ? 1 : 0;
        else if (e[0])     g = 0;
        else if (e[1])     g = 1;
        else               g = -1;
        chk("r0_ready", {31'd0, r0_ready}, {31'd0, g == 0});
        chk("r1_ready", {31'd0, r1_ready}, {31'd0, g == 1});
        chk("alu_op1", alu_op1, (g == 1) ? a1 : a0);
        chk("alu_op2", alu_op2, (g == 1) ? b1 : b0);
        chk("alu_op_sel", {28'd0, alu_op_sel}, {28'd0, (g == 1) ? op1 : op0});
        chk("s0_valid", {31'd0, s0_valid}, {31'd0, m_valid[0]});
        chk("s1_valid", {31'd0, s1_valid}, {31'd0, m_valid[1]});
        chk("s0_result", s0_result, m_res[0]);
        chk("s1_result", s1_result, m_res[1]);
        chk("s0_flags", {29'd0, s0_n, s0_z, s0_wr}, {29'd0, m_n[0], m_z[0], m_wr[0]});
        chk("s1_flags", {29'd0, s1_n, s1_z, s1_wr}, {29'd0, m_n[1], m_z[1], m_wr[1]});
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                m_valid[p] = 1'b0; m_res[p] = '0; m_n[p] = 1'b0; m_z[p] = 1'b0; m_wr[p] = 1'b0;
            end
            m_last = 1;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (p == g) begin
                    res        = alu_f(op[p], a[p], b[p]);
                    m_valid[p] = 1'b1;
                    m_res[p]   = res;
                    m_n[p]     = res[31];
                    m_z[p]     = (res == 32'd0);
                    m_wr[p]    = !(op[p] >= 4'd8 && op[p] <= 4'd11);
                end else if (m_valid[p] && rd[p]) begin
                    m_valid[p] = 1'b0;
                end
            end
            if (g >= 0) m_last = g;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra, rb, rc, rdd;
        logic [31:0] held;
        reset = 1'b1; r0_valid = 0; r1_valid = 0; s0_ready = 0; s1_ready = 0;
        r0_op1 = 0; r0_op2 = 0; r1_op1 = 0; r1_op2 = 0; r0_sel = 0; r1_sel = 0;
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0; m_res[p] = '0; m_n[p] = 1'b0; m_z[p] = 1'b0; m_wr[p] = 1'b0;
        end
        m_last = 1;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Single ADD 5+7 on port 0
        cycle(0, 1, 0, 32'd5, 32'd7, 4'd4, 0, 0, 0, 1, 1);
        chk("add_result", s0_result, 32'd12);
        chk("add_flags", {28'd0, s0_valid, s0_n, s0_z, s0_wr}, {28'd0, 4'b1001});
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Contention: expect 0,1,0,1 after a reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 1, k, 1, 4'd4, k, 2, 4'd4, 1, 1);
            chk("rr_order", {31'd0, s1_valid && (s1_result == k + 2)}, {31'd0, (k % 2) == 1});
        end

        // CMP 3,3 and SUB 2,3 on port 1
        cycle(0, 0, 1, 0, 0, 0, 32'd3, 32'd3, 4'd10, 1, 1);
        chk("cmp_result", s1_result, 32'd0);
        chk("cmp_flags", {29'd0, s1_n, s1_z, s1_wr}, {29'd0, 3'b010});
        cycle(0, 0, 1, 0, 0, 0, 32'd2, 32'd3, 4'd2, 1, 1);
        chk("sub_result", s1_result, 32'hFFFF_FFFF);
        chk("sub_flags", {29'd0, s1_n, s1_z, s1_wr}, {29'd0, 3'b101});

        // Backpressure on port 0 while port 1 keeps flowing
        cycle(0, 1, 0, 32'd100, 32'd1, 4'd4, 0, 0, 0, 0, 1);
        held = s0_result;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 1, 32'd9, 32'd9, 4'd4, k, 32'd10, 4'd4, 0, 1);
            chk("bp_s0_hold", s0_result, held);
            chk("bp_s1_flow", s1_result, k + 10);
        end
        cycle(0, 1, 0, 32'd20, 32'd22, 4'd4, 0, 0, 0, 1, 1);
        chk("bp_refill", {31'd0, s0_valid}, 32'd1);
        chk("bp_refill_res", s0_result, 32'd42);

        // Reset mid-stream with both responses held
        cycle(0, 1, 0, 1, 1, 4'd4, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 1, 1, 4'd4, 0, 0);
        chk("pre_rst_valids", {30'd0, s1_valid, s0_valid}, 32'd3);
        cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_valids", {30'd0, s1_valid, s0_valid}, 32'd0);
        cycle(0, 1, 1, 32'd7, 32'd0, 4'd13, 32'd8, 32'd0, 4'd13, 1, 1);
        chk("rst_first_win", {30'd0, s1_valid, s0_valid}, 32'd1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc = $urandom; rdd = ($urandom_range(0, 3) == 0) ? rc : $urandom;
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  ra, rb, 4'($urandom_range(0, 15)),
                  rc, rdd, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_alu_arbiter.md
ARM_ALU_ARBITER -- requirements
Module: arm_alu_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line, in this order:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid, r1_valid  in  1 each  requester N presents an operation.
- r0_ready, r1_ready  out  1 each  requester N operation accepted this cycle.
- r0_op1, r0_op2, r1_op1, r1_op2  in  32 each  operands.
- r0_sel, r1_sel  in  4 each  ARM data-processing opcode.
- alu_op1, alu_op2  out  32 each  operands driven to the shared ALU.
- alu_op_sel  out  4  opcode driven to the shared ALU.
- alu_out  in  32  combinational ALU result.
- s0_valid, s1_valid  out  1 each  response N holds a result.
- s0_ready, s1_ready  in  1 each  consumer N takes the response.
- s0_result, s1_result  out  32 each  captured ALU result.
- s0_n, s0_z, s1_n, s1_z  out  1 each  result bit 31; result == 0.
- s0_wr, s1_wr  out  1 each  opcode writes Rd.

REQ-002 Opcode encoding SHALL be the 4-bit ARM encoding used by the ALU: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=10, CMN=11, ORR=12, MOV=13, BIC=14, MVN=15.

Function
REQ-003 Port N SHALL be eligible in a cycle when rN_valid=1 and either sN_valid=0 or sN_ready=1 in that cycle.
REQ-004 At most one port SHALL be granted per cycle. A single eligible port SHALL win. When both are eligible, the port other than last_grant SHALL win (round-robin).
REQ-005 last_grant (1 bit) SHALL update to the granted port on every grant cycle and SHALL hold otherwise.
REQ-006 rN_ready SHALL be 1 only in the cycle port N is granted. It is combinational from the valid inputs, the s-state and sN_ready.
REQ-007 During a grant cycle, alu_op1/alu_op2/alu_op_sel SHALL equal the granted port's operands and opcode. With no grant they SHALL equal port 0's inputs (don't-care to the ALU).
REQ-008 On a grant to port N, at the next edge the block SHALL:
- capture alu_out into sN_result;
- set sN_n = alu_out[31] and sN_z = (alu_out == 0);
- set sN_wr = 0 for opcodes 8–11 and 1 otherwise;
- set sN_valid = 1.
Accept-to-response latency is exactly 1 cycle.
REQ-009 sN_valid SHALL clear at the edge following a cycle with sN_valid=1, sN_ready=1 and no new grant to port N.
REQ-010 Simultaneous drain and grant on port N SHALL leave sN_valid=1 with the new result. No cycle SHALL show a bubble or a lost result.
REQ-011 While sN_valid=1 and sN_ready=0, sN_result/n/z/wr SHALL hold stable, and port N SHALL NOT be granted (backpressure).
REQ-012 A port blocked by backpressure SHALL NOT block the other port. The other port SHALL be granted every cycle it is eligible.
REQ-013 rN_valid SHALL be permitted to deassert without a grant. The block SHALL NOT retain requests internally.
REQ-014 Undefined opcodes SHALL NOT exist (all 16 are defined). The block SHALL pass alu_out through unmodified, including X.

Reset
REQ-015 While reset=1 at a clock edge, the following SHALL be cleared at that edge:
- s0_valid and s1_valid;
- s0/s1_result, n, z and wr (all to 0).
REQ-016 While reset=1 at a clock edge, last_grant SHALL be set to 1, so port 0 wins the first contention.
REQ-017 While reset=1, r0_ready and r1_ready SHALL be 0 and no capture SHALL occur.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight or held response. No response from before reset SHALL appear after reset deasserts.

Verification
REQ-019 Single request: r0 ADD 5+7, s0_ready=1.
-> r0_ready=1 in cycle 0.
-> Next cycle: s0_valid=1, s0_result=12, n=0, z=0, wr=1.
REQ-020 Contention after reset: both ports valid every cycle, consumers always ready.
-> Grants alternate 0,1,0,1.
-> s0/s1 responses each appear 1 cycle after their grant.
REQ-021 Compare flags: r1 CMP 3,3.
-> s1_result=0, z=1, n=0, wr=0.
REQ-021a Subtract flags: r1 SUB 2,3.
-> s1_result=0xFFFFFFFF, n=1, z=0, wr=1.
REQ-022 Backpressure: s0_ready=0 with s0_valid=1, both requesters valid.
-> r0_ready=0.
-> Port 1 granted every cycle; s0 outputs stable.
-> Once s0_ready=1, r0 granted that same cycle (drain+refill) and s0_valid stays 1.
REQ-023 Reset mid-stream: assert reset for 1 cycle while s0_valid=1 and s1_valid=1.
-> Both valids 0 next cycle.
-> First contention after reset grants port 0.
